// File: rtl/decode_stream_pkg.sv
// Shared widths, state encoding and width clamp for the LZS bit-stream unpacker.
package decode_stream_pkg;

  localparam int unsigned IW          = 32;  // input word width
  localparam int unsigned BW          = 64;  // bit-buffer width, 2*IW
  localparam int unsigned WW          = 13;  // peek window width
  localparam int unsigned MAX_CONSUME = 13;
  localparam int unsigned CW          = 7;   // bit count 0..64
  localparam int unsigned SW          = 4;   // consume width field

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [SW-1:0] clamp_width(input logic [SW-1:0] w);
    return (w > SW'(MAX_CONSUME)) ? SW'(MAX_CONSUME) : w;
  endfunction

endpackage

// File: rtl/decode_stream_bitbuf.sv
// Left barrel shift of the bit buffer followed by OR-insert of a word
// directly below the remaining valid bits.
module decode_stream_bitbuf
  import decode_stream_pkg::*;
(
  input  logic [BW-1:0] i_buf,
  input  logic [SW-1:0] i_shift,
  input  logic          i_ins_en,
  input  logic [CW-1:0] i_ins_off,
  input  logic [IW-1:0] i_word,
  output logic [BW-1:0] o_buf
);

  logic [BW-1:0] w_shifted;
  logic [BW-1:0] w_insert;

  // Offset is the post-shift count, so the word lands contiguous with the survivors.
  always_comb begin
    w_shifted = i_buf << i_shift;
    w_insert  = {i_word, {IW{1'b0}}} >> i_ins_off;
    o_buf     = i_ins_en ? (w_shifted | w_insert) : w_shifted;
  end

endmodule

// File: rtl/decode_stream.sv
// Bit-stream unpacker: pops 32-bit words into a 64-bit MSB-first buffer and
// exposes a 13-bit peek window consumed by width + ack.
module decode_stream
  import decode_stream_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic [IW-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ack,
  output logic [WW-1:0] stream_data,
  output logic          stream_valid,
  output logic          stream_done,
  input  logic [SW-1:0] stream_width,
  input  logic          stream_ack
);

  state_t        r_state;
  state_t        w_state_next;
  logic [BW-1:0] r_buf;
  logic [BW-1:0] w_buf_upd;
  logic [BW-1:0] w_buf_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_shift;
  logic [CW-1:0] w_cnt_next;
  logic          r_last_seen;
  logic          w_last_seen_next;
  logic [SW-1:0] w_consume;

  // Pop decision uses only registered count, never the same-cycle consume.
  assign in_ack       = in_valid && (r_state == S_RUN) && (r_cnt <= CW'(IW));
  assign stream_valid = ((r_state == S_RUN) && (r_cnt >= CW'(WW))) ||
                        ((r_state == S_DRAIN) && (r_cnt != CW'(0)));
  assign stream_done  = (r_state == S_DONE);
  assign stream_data  = r_buf[BW-1 -: WW];

  assign w_consume   = (stream_ack && stream_valid) ? clamp_width(stream_width) : SW'(0);
  // Over-consume of trailing padding saturates at zero.
  assign w_cnt_shift = (CW'(w_consume) > r_cnt) ? CW'(0) : (r_cnt - CW'(w_consume));

  decode_stream_bitbuf u_bitbuf (
    .i_buf     (r_buf),
    .i_shift   (w_consume),
    .i_ins_en  (in_ack),
    .i_ins_off (w_cnt_shift),
    .i_word    (in_data),
    .o_buf     (w_buf_upd)
  );

  // Next-state, buffer and count update.
  always_comb begin
    w_state_next     = r_state;
    w_buf_next       = w_buf_upd;
    w_cnt_next       = w_cnt_shift + (in_ack ? CW'(IW) : CW'(0));
    w_last_seen_next = r_last_seen;
    case (r_state)
      S_IDLE: begin
        w_buf_next       = '0;
        w_cnt_next       = '0;
        w_last_seen_next = 1'b0;
        if (ce) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (in_ack && in_last) begin
          w_last_seen_next = 1'b1;
          w_state_next     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_last_seen && (w_cnt_next == CW'(0))) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (!ce) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_buf       <= '0;
      r_cnt       <= '0;
      r_last_seen <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_buf       <= w_buf_next;
      r_cnt       <= w_cnt_next;
      r_last_seen <= w_last_seen_next;
    end
  end

  // Widths above the window are clamped in hardware but flag a controller bug.
  always_ff @(posedge clk) begin
    if (!rst && stream_ack && stream_valid)
      assert (stream_width <= SW'(MAX_CONSUME));
  end

endmodule

// File: tb/tb_decode_stream.sv
// Directed and short random checks of decode_stream against a bit-queue reference.
module tb_decode_stream;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DONE  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ack;
  logic [12:0] stream_data;
  logic        stream_valid;
  logic        stream_done;
  logic [3:0]  stream_width;
  logic        stream_ack;

  int n_cmp = 0;
  int n_err = 0;
  int ms    = M_IDLE;
  bit q[$];
  bit last_pop;
  bit last_ack_obs;

  decode_stream dut (
    .clk          (clk),
    .rst          (rst),
    .ce           (ce),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ack       (in_ack),
    .stream_data  (stream_data),
    .stream_valid (stream_valid),
    .stream_done  (stream_done),
    .stream_width (stream_width),
    .stream_ack   (stream_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] ref_window();
    logic [12:0] r;
    r = '0;
    for (int i = 0; i < 13; i++)
      if (i < q.size()) r[12-i] = q[i];
    return r;
  endfunction

  // Called with clk low and inputs already set; checks outputs, advances the reference, crosses one edge.
  task automatic step(input string tag);
    bit ev, ea, ed;
    int w;
    #1;
    ev = ((ms == M_RUN) && (q.size() >= 13)) || ((ms == M_DRAIN) && (q.size() > 0));
    ea = in_valid && (ms == M_RUN) && (q.size() <= 32);
    ed = (ms == M_DONE);
    check({tag, ".valid"}, 32'(stream_valid), 32'(ev));
    check({tag, ".ack"},   32'(in_ack),       32'(ea));
    check({tag, ".done"},  32'(stream_done),  32'(ed));
    check({tag, ".data"},  32'(stream_data),  32'(ref_window()));
    last_ack_obs = in_ack;
    w = (stream_ack && ev) ? ((int'(stream_width) > 13) ? 13 : int'(stream_width)) : 0;
    for (int i = 0; i < w; i++)
      if (q.size() > 0) void'(q.pop_front());
    if (ea)
      for (int i = 31; i >= 0; i--) q.push_back(in_data[i]);
    case (ms)
      M_IDLE:  if (ce) ms = M_RUN;
      M_RUN:   if (ea && in_last) ms = M_DRAIN;
      M_DRAIN: if (q.size() == 0) ms = M_DONE;
      default: if (!ce) begin ms = M_IDLE; q.delete(); end
    endcase
    last_pop = ea;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int pops;
    int words_left;
    rst = 1'b1; ce = 1'b0; in_data = '0; in_valid = 1'b1; in_last = 1'b0;
    stream_width = '0; stream_ack = 1'b0;
    #3;
    check("rst.data",  32'(stream_data),  32'h0);
    check("rst.valid", 32'(stream_valid), 32'h0);
    check("rst.done",  32'(stream_done),  32'h0);
    check("rst.ack",   32'(in_ack),       32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;

    // Single last word, then peek and consume 9.
    ce = 1'b1; in_valid = 1'b1; in_data = 32'h12345678; in_last = 1'b1;
    step("t1_ce");
    step("t1_pop");
    in_valid = 1'b0; in_last = 1'b0;
    check("t1_data0", 32'(stream_data), 32'h0246);
    check("t1_valid", 32'(stream_valid), 32'h1);
    stream_ack = 1'b1; stream_width = 4'd9;
    step("t1_ack9");
    check("t1_data9", 32'(stream_data), 32'h0D15);

    // Drain to 5 bits, consume exactly, done, back to idle.
    stream_width = 4'd13; step("t2_a13");
    stream_width = 4'd5;  step("t2_a5");
    check("t2_tail", 32'(stream_data), 32'h1800);
    check("t2_valid5", 32'(stream_valid), 32'h1);
    step("t2_last5");
    stream_ack = 1'b0;
    check("t2_done", 32'(stream_done), 32'h1);
    ce = 1'b0;
    step("t2_idle");
    check("t2_idle_done", 32'(stream_done), 32'h0);

    // Over-consume of padding in drain.
    ce = 1'b1; in_valid = 1'b1; in_data = 32'h9ABCDEF7; in_last = 1'b1;
    step("t6_ce");
    step("t6_pop");
    in_valid = 1'b0; in_last = 1'b0; stream_ack = 1'b1;
    stream_width = 4'd13; step("t6_a13a");
    step("t6_a13b");
    stream_width = 4'd3; step("t6_a3");
    check("t6_tail3", 32'(stream_data), 32'h1C00);
    stream_width = 4'd9; step("t6_a9");
    check("t6_done", 32'(stream_done), 32'h1);
    stream_ack = 1'b0; ce = 1'b0;
    step("t6_idle");

    // Backpressure: exactly two pops fill the buffer.
    ce = 1'b1; in_valid = 1'b1; in_data = 32'hA5A5A5A5; in_last = 1'b0;
    step("t3_ce");
    pops = 0;
    for (int i = 0; i < 5; i++) begin
      step("t3_fill");
      if (last_ack_obs) pops++;
    end
    check("t3_pops", 32'(pops), 32'd2);
    check("t3_data", 32'(stream_data), 32'h14B4);
    stream_ack = 1'b1; stream_width = 4'd13;
    step("t3_a13");
    stream_ack = 1'b0;
    step("t3_hold");
    check("t3_nopop51", 32'(last_ack_obs), 32'h0);
    check("t3_data51", 32'(stream_data), 32'h1696);

    // Reset mid-stream with 40 bits buffered.
    stream_ack = 1'b1; stream_width = 4'd11;
    step("t5_a11");
    stream_ack = 1'b0;
    rst = 1'b1;
    #1;
    check("t5_data",  32'(stream_data),  32'h0);
    check("t5_valid", 32'(stream_valid), 32'h0);
    check("t5_done",  32'(stream_done),  32'h0);
    check("t5_ack",   32'(in_ack),       32'h0);
    ms = M_IDLE; q.delete();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;

    // Consume and pop in the same cycle across a word seam.
    ce = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF; in_last = 1'b0;
    step("t4_ce");
    step("t4_popA");
    in_data = 32'h0F0F0F0F; stream_ack = 1'b1; stream_width = 4'd13;
    check("t4_dataA", 32'(stream_data), 32'h1BD5);
    step("t4_seam");
    check("t4_popB", 32'(last_ack_obs), 32'h1);
    in_valid = 1'b0;
    check("t4_data13", 32'(stream_data), 32'h16FB);
    step("t4_a13");
    check("t4_data26", 32'(stream_data), 32'h1787);

    // Random gaps and widths, finishing with a last word and drain.
    words_left = 6;
    in_data = $urandom;
    for (int c = 0; c < 600 && ms != M_DONE; c++) begin
      in_valid     = (words_left > 0) && ($urandom_range(0, 3) != 0);
      in_last      = (words_left == 1);
      stream_ack   = 1'($urandom_range(0, 1));
      stream_width = 4'($urandom_range(0, 13));
      step("rnd");
      if (last_pop) begin
        words_left--;
        in_data = $urandom;
      end
    end
    in_valid = 1'b0; stream_ack = 1'b0;
    check("rnd_done", 32'(stream_done), 32'h1);
    ce = 1'b0;
    step("rnd_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
